cwc_trace_reader: RTL and testbench
===================================

# cwc_trace_reader

Trace-buffer readback engine for the ChipWatcher capture core. Once the capture side has stopped writing samples into trace RAM, it reads the RAM back in chronological order, oldest sample first, handling the circular-buffer wrap point. It serializes each sample LSB-first onto the JTAG data-out path with no gaps between words. It sits in the JTAG clock domain between the trace RAM read port and the `jtdo` scan chain.

## Interface
Parameters:
- `DATA_WIDTH`, 50: bits per captured sample (non-bus plus bus nodes); must be ≥ 3.
- `ADDR_WIDTH`, 16: trace RAM address width.
- `DEPTH`, 1024: number of samples in trace RAM; need not be a power of two; must be ≤ 2^ADDR_WIDTH.

Ports:
- `jtck`, in, 1: the single clock; all logic is on its rising edge.
- `jrst`, in, 1: reset, synchronous, active-high.
- `rd_start`, in, 1: single-cycle pulse that starts a readback.
- `cap_waddr`, in, ADDR_WIDTH: next write address at capture stop; always < DEPTH; sampled on `rd_start`.
- `cap_wrapped`, in, 1: the buffer has been filled at least once; sampled on `rd_start`.
- `rd_ce`, out, 1: trace RAM read enable.
- `rd_addr`, out, ADDR_WIDTH: trace RAM read address.
- `rd_data`, in, DATA_WIDTH: RAM read data; valid exactly 1 cycle after `rd_ce`.
- `jshift`, in, 1: shift-enable; one bit advances per cycle while high.
- `jtdo`, out, 1: serial sample data, LSB first.
- `rd_busy`, out, 1: a readback is in progress.
- `rd_done`, out, 1: 1-cycle pulse when the readback completes.

## Operation
- Setup on `rd_start` in IDLE:
  - If `cap_wrapped=1`: first address = `cap_waddr`, word count = DEPTH.
  - If `cap_wrapped=0`: first address = 0, word count = `cap_waddr`.
  - If the word count is 0: go to DONE directly; no `rd_ce` is issued.
- State machine (IDLE, FETCH, LOAD, SHIFT, DONE):
  - IDLE: waits for `rd_start`.
  - FETCH: asserts `rd_ce` at the first address, then goes to LOAD.
  - LOAD: captures `rd_data` into the shift register, clears the bit counter, decrements the words-remaining count, then goes to SHIFT.
  - SHIFT, prefetch: if words remain and the hold register is empty, issue one `rd_ce` at the next address (once only). Capture `rd_data` into the hold register the following cycle and set `hold_valid`.
  - SHIFT, shifting: each cycle with `jshift=1`, shift right and increment the bit counter.
  - SHIFT, end of word: on bit index DATA_WIDTH-1 with `jshift=1`:
    - if `hold_valid`, move the hold register into the shift register, clear `hold_valid`, reset the bit counter, and stay in SHIFT;
    - otherwise go to DONE.
  - DONE: pulses `rd_done` for one cycle, then goes to IDLE.
- Address increment: `addr==DEPTH-1` wraps to 0; otherwise `addr+1`.
- `jtdo` = shift register bit 0, registered output. It holds its value while `jshift=0`.
- `rd_start` while `rd_busy=1` is ignored.
- `jshift` in IDLE or DONE has no effect.
- Reset, including mid-readback: state goes to IDLE and all registers clear. No `rd_done` is produced for an aborted readback.

## Timing
- Reset values: `rd_ce=0`, `rd_addr=0`, `jtdo=0`, `rd_busy=0`, `rd_done=0`, `hold_valid=0`.
- Startup latency, with `rd_start` high in cycle t:
  - t+1: FETCH; `rd_busy=1` and `rd_ce=1`.
  - t+2: LOAD.
  - t+3: SHIFT; `jtdo` shows bit 0 of the oldest sample.
- Prefetch completes by the 3rd SHIFT cycle. Because DATA_WIDTH ≥ 3, a continuous `jshift` produces no gap between words.
- `rd_done`: high in the cycle after the last bit's shift edge. `rd_busy` drops in that same cycle.
- Empty readback (word count 0): `rd_done` is high at t+1.
- Throughput: exactly one `rd_ce` pulse per word; the total is N words and N×DATA_WIDTH shifted bits.

## Structure
- Shared package `cwc_pkg` holds:
  - the state enum `cwc_rd_state_t`;
  - a `cwc_next_addr` wrap function parameterized by DEPTH.
- Sub-module `cwc_rd_serializer` contains the shift register, hold register, `hold_valid` and bit counter. It exposes `load`, `hold_wr`, `word_end` and `jtdo`.
- The top module keeps the FSM, the address counter and the words-remaining counter.

## Test plan
1. Linear readback. Setup: DEPTH=8, DATA_WIDTH=4, mem[i]=i+1, `cap_waddr=3`, `cap_wrapped=0`, `jshift` held at 1. Expected: `rd_addr` sequence 0,1,2; `jtdo` stream 1000 0100 1100; exactly 3 `rd_ce` pulses; `rd_done` one cycle after the 12th bit.
2. Wrapped readback. Setup: same memory, `cap_waddr=6`, `cap_wrapped=1`. Expected: `rd_addr` sequence 6,7,0,1,2,3,4,5; 32 bits with no gaps; 8 `rd_ce` pulses.
3. Empty readback. Setup: `cap_waddr=0`, `cap_wrapped=0`. Expected: `rd_done` at t+1; no `rd_ce`; `jtdo` stays 0.
4. Stalled shifting. Setup: as scenario 1, with `jshift` toggled 1,0,1,0. Expected: the same 12-bit stream; `jtdo` holds its value on `jshift=0` cycles; no extra `rd_ce`.
5. Reset and busy abuse.
   - Pulse `rd_start` again in the middle of a readback: ignored.
   - Assert `jrst` during the 2nd word: IDLE next cycle, all outputs at reset values, no `rd_done`.
   - Then start a new readback: it completes normally.

Source files
------------

// File: rtl/cwc_pkg.sv
// Shared types and helpers for the ChipWatcher trace readback path.
package cwc_pkg;

   // Readback sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_SHIFT,
      ST_DONE
   } cwc_rd_state_t;

   // Next trace RAM address; the buffer wraps at depth, which need not be a power of two.
   function automatic logic [31:0] cwc_next_addr(input logic [31:0] addr,
                                                 input int unsigned depth);
      if (addr == depth - 1) begin
         return '0;
      end
      return addr + 32'd1;
   endfunction

endpackage

// File: rtl/cwc_rd_serializer.sv
// Sample serializer: a shift register feeding jtdo LSB-first, backed by one
// hold register so the next sample is ready at the word boundary without a gap.
module cwc_rd_serializer #(
   parameter int unsigned DATA_WIDTH = 50
) (
   input  logic                  jtck,
   input  logic                  jrst,
   input  logic                  load,
   input  logic                  hold_wr,
   input  logic                  shift_en,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  word_end,
   output logic                  hold_valid,
   output logic                  jtdo
);

   localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] hold_reg;
   logic [CNT_W-1:0]      bit_cnt;

   // The last bit of the current word leaves on this shift edge.
   assign word_end = shift_en && (bit_cnt == LAST_BIT);

   // Shift, reload from RAM or hold register, and track the hold register fill state.
   always_ff @(posedge jtck) begin
      if (jrst) begin
         // NOTE: the sample registers are cleared as well, so an aborted readback
         // can never leak a stale sample onto jtdo after reset.
         shift_reg  <= '0;
         hold_reg   <= '0;
         hold_valid <= 1'b0;
         bit_cnt    <= '0;
         jtdo       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here sees
         // the pre-edge value of its neighbours (jtdo takes the old shift_reg[1]).
         if (load) begin
            shift_reg <= rd_data;
            jtdo      <= rd_data[0];
            bit_cnt   <= '0;
         end else if (word_end && hold_valid) begin
            shift_reg <= hold_reg;
            jtdo      <= hold_reg[0];
            bit_cnt   <= '0;
         end else if (shift_en) begin
            shift_reg <= shift_reg >> 1;
            jtdo      <= shift_reg[1];
            bit_cnt   <= word_end ? '0 : bit_cnt + CNT_W'(1);
         end

         if (hold_wr) begin
            hold_reg   <= rd_data;
            hold_valid <= 1'b1;
         end else if (word_end && hold_valid) begin
            hold_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cwc_trace_reader.sv
// Trace buffer readback engine: walks the circular trace RAM oldest-first and
// streams each sample LSB-first onto jtdo with no gaps between words.
module cwc_trace_reader
   import cwc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 50,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DEPTH      = 1024
) (
   input  logic                  jtck,
   input  logic                  jrst,
   input  logic                  rd_start,
   input  logic [ADDR_WIDTH-1:0] cap_waddr,
   input  logic                  cap_wrapped,
   output logic                  rd_ce,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  jshift,
   output logic                  jtdo,
   output logic                  rd_busy,
   output logic                  rd_done
);

   cwc_rd_state_t         state;
   logic [ADDR_WIDTH:0]   words_left;   // RAM reads still to be issued
   logic                  hold_wr;      // prefetch data is on rd_data this cycle
   logic                  hold_valid;
   logic                  word_end;

   logic [ADDR_WIDTH-1:0] start_addr;
   logic [ADDR_WIDTH:0]   start_count;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic                  fetch_ok;

   // Readback window, next address and prefetch permission.
   always_comb begin
      // NOTE: every output of this block is given a value on every path, so no
      // latch can be inferred.
      start_addr  = cap_wrapped ? cap_waddr : '0;
      start_count = cap_wrapped ? (ADDR_WIDTH + 1)'(DEPTH) : {1'b0, cap_waddr};
      next_addr   = ADDR_WIDTH'(cwc_next_addr(32'(rd_addr), DEPTH));
      // One read in flight at most, and only when the hold register is free or
      // is being emptied on this very edge.
      fetch_ok    = (words_left != '0) && !rd_ce && !hold_wr && (!hold_valid || word_end);
   end

   // Sequencer with registered RAM strobe, address and status outputs.
   always_ff @(posedge jtck) begin
      if (jrst) begin
         state      <= ST_IDLE;
         rd_ce      <= 1'b0;
         rd_addr    <= '0;
         rd_busy    <= 1'b0;
         rd_done    <= 1'b0;
         words_left <= '0;
         hold_wr    <= 1'b0;
      end else begin
         rd_ce   <= 1'b0;
         rd_done <= 1'b0;
         hold_wr <= rd_ce && (state == ST_SHIFT);
         case (state)
            ST_IDLE: begin
               if (rd_start) begin
                  if (start_count == '0) begin
                     state   <= ST_DONE;
                     rd_done <= 1'b1;
                  end else begin
                     state      <= ST_FETCH;
                     rd_busy    <= 1'b1;
                     rd_ce      <= 1'b1;
                     rd_addr    <= start_addr;
                     words_left <= start_count - 1'b1;
                  end
               end
            end
            ST_FETCH: begin
               state <= ST_LOAD;
            end
            ST_LOAD: begin
               state <= ST_SHIFT;
               if (fetch_ok) begin
                  rd_ce      <= 1'b1;
                  rd_addr    <= next_addr;
                  words_left <= words_left - 1'b1;
               end
            end
            ST_SHIFT: begin
               if (word_end && !hold_valid) begin
                  state   <= ST_DONE;
                  rd_busy <= 1'b0;
                  rd_done <= 1'b1;
               end else if (fetch_ok) begin
                  rd_ce      <= 1'b1;
                  rd_addr    <= next_addr;
                  words_left <= words_left - 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   cwc_rd_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ser (
      .jtck       (jtck),
      .jrst       (jrst),
      .load       (state == ST_LOAD),
      .hold_wr    (hold_wr),
      .shift_en   (jshift && (state == ST_SHIFT)),
      .rd_data    (rd_data),
      .word_end   (word_end),
      .hold_valid (hold_valid),
      .jtdo       (jtdo)
   );

endmodule

// File: tb/tb_cwc_trace_reader.sv
// Directed bench for cwc_trace_reader with an 8-deep, 4-bit trace RAM (mem[i] = i+1).
module tb_cwc_trace_reader;

   localparam int unsigned DW      = 4;
   localparam int unsigned AW      = 16;
   localparam int unsigned DEP     = 8;
   localparam int          MAX_CYC = 200;

   logic          jtck = 1'b0;
   logic          jrst = 1'b1;
   logic          rd_start = 1'b0;
   logic [AW-1:0] cap_waddr = '0;
   logic          cap_wrapped = 1'b0;
   logic          rd_ce;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data = '0;
   logic          jshift = 1'b0;
   logic          jtdo;
   logic          rd_busy;
   logic          rd_done;

   logic [DW-1:0] mem [DEP];

   int total = 0;
   int bad   = 0;

   // Observations gathered by run_readback.
   int          n_ce;
   int          n_bits;
   logic [63:0] stream;
   logic [63:0] addr_seq;
   int          done_idx;
   int          last_bit_idx;
   int          hold_err;
   logic        busy_at1;
   logic        ce_at1;
   logic        busy_at_done;
   logic        timed_out;

   cwc_trace_reader #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEP)
   ) dut (
      .jtck        (jtck),
      .jrst        (jrst),
      .rd_start    (rd_start),
      .cap_waddr   (cap_waddr),
      .cap_wrapped (cap_wrapped),
      .rd_ce       (rd_ce),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .jshift      (jshift),
      .jtdo        (jtdo),
      .rd_busy     (rd_busy),
      .rd_done     (rd_done)
   );

   always #5 jtck = ~jtck;

   // Trace RAM: data one cycle after rd_ce.
   always @(posedge jtck) begin
      if (rd_ce) rd_data <= mem[rd_addr[2:0]];
   end

   // Starts a readback and records what the DUT does until rd_done or timeout.
   // Cycle idx counts negedges after the rd_start edge (idx 1 = t+1).
   task automatic run_readback(input logic [AW-1:0] waddr, input logic wrapped,
                               input bit stall, input bit abuse);
      logic prev_js;
      logic prev_jtdo;
      logic js;
      n_ce = 0; n_bits = 0; stream = '0; addr_seq = '0;
      done_idx = -1; last_bit_idx = -1; hold_err = 0;
      busy_at1 = 1'b0; ce_at1 = 1'b0; busy_at_done = 1'b1; timed_out = 1'b1;
      prev_js = 1'b1; prev_jtdo = 1'b0;
      @(negedge jtck);
      cap_waddr = waddr; cap_wrapped = wrapped; rd_start = 1'b1; jshift = 1'b1;
      for (int idx = 1; idx <= MAX_CYC; idx++) begin
         @(negedge jtck);
         rd_start = 1'b0;
         if (idx == 1) begin
            busy_at1 = rd_busy;
            ce_at1   = rd_ce;
         end
         if (rd_ce) begin
            if (n_ce < 8) addr_seq[n_ce*8 +: 8] = rd_addr[7:0];
            n_ce++;
         end
         if (rd_done) begin
            done_idx     = idx;
            busy_at_done = rd_busy;
            timed_out    = 1'b0;
            break;
         end
         if (idx >= 4 && !prev_js && rd_busy && jtdo !== prev_jtdo) hold_err++;
         js = (stall && idx >= 3) ? ((idx - 3) % 2 == 0) : 1'b1;
         jshift = js;
         if (idx >= 3 && js && rd_busy) begin
            if (n_bits < 64) stream[n_bits] = jtdo;
            n_bits++;
            last_bit_idx = idx;
         end
         prev_js   = js;
         prev_jtdo = jtdo;
         if (abuse && idx == 5) begin
            rd_start = 1'b1; cap_waddr = 16'd5; cap_wrapped = 1'b1;
         end
      end
      rd_start = 1'b0;
      jshift   = 1'b0;
   endtask

   task automatic test_reset();
      jrst = 1'b1; jshift = 1'b1; rd_start = 1'b1;
      repeat (3) @(negedge jtck);
      total++; if ({rd_ce, rd_busy, rd_done, jtdo} !== 4'b0000) begin
         bad++; $display("FAIL reset_ctl: ce/busy/done/jtdo=%b want 0000", {rd_ce, rd_busy, rd_done, jtdo});
      end
      total++; if (rd_addr !== '0) begin
         bad++; $display("FAIL reset_addr: got %0d want 0", rd_addr);
      end
      total++; if (dut.hold_valid !== 1'b0) begin
         bad++; $display("FAIL reset_hold_valid: got %b want 0", dut.hold_valid);
      end
      rd_start = 1'b0; jshift = 1'b0; jrst = 1'b0;
      @(negedge jtck);
   endtask

   task automatic test_empty();
      run_readback(16'd0, 1'b0, 1'b0, 1'b0);
      total++; if (done_idx !== 1) begin
         bad++; $display("FAIL empty_done_cycle: got %0d want 1", done_idx);
      end
      total++; if (n_ce !== 0) begin
         bad++; $display("FAIL empty_rd_ce: got %0d pulses want 0", n_ce);
      end
      total++; if (busy_at1 !== 1'b0) begin
         bad++; $display("FAIL empty_busy: got %b want 0", busy_at1);
      end
      total++; if (jtdo !== 1'b0) begin
         bad++; $display("FAIL empty_jtdo: got %b want 0", jtdo);
      end
      @(negedge jtck);
      total++; if (rd_done !== 1'b0) begin
         bad++; $display("FAIL empty_done_width: got %b want 0", rd_done);
      end
   endtask

   task automatic test_linear();
      run_readback(16'd3, 1'b0, 1'b0, 1'b0);
      total++; if (timed_out !== 1'b0) begin
         bad++; $display("FAIL linear_timeout: no rd_done within %0d cycles", MAX_CYC);
      end
      total++; if ({busy_at1, ce_at1} !== 2'b11) begin
         bad++; $display("FAIL linear_startup: busy/ce at t+1=%b want 11", {busy_at1, ce_at1});
      end
      total++; if (addr_seq[23:0] !== 24'h020100 || n_ce !== 3) begin
         bad++; $display("FAIL linear_addr: seq=%h n=%0d want 020100 n=3", addr_seq[23:0], n_ce);
      end
      total++; if (stream[11:0] !== 12'h321 || n_bits !== 12) begin
         bad++; $display("FAIL linear_stream: got %h (%0d bits) want 321 (12 bits)", stream[11:0], n_bits);
      end
      total++; if (done_idx !== 15 || last_bit_idx !== 14) begin
         bad++; $display("FAIL linear_done_cycle: done=%0d last_bit=%0d want 15/14", done_idx, last_bit_idx);
      end
      total++; if (busy_at_done !== 1'b0) begin
         bad++; $display("FAIL linear_busy_at_done: got %b want 0", busy_at_done);
      end
   endtask

   task automatic test_wrapped();
      run_readback(16'd6, 1'b1, 1'b0, 1'b0);
      total++; if (addr_seq !== 64'h0504030201000706 || n_ce !== 8) begin
         bad++; $display("FAIL wrap_addr: seq=%h n=%0d want 0504030201000706 n=8", addr_seq, n_ce);
      end
      total++; if (stream[31:0] !== 32'h65432187 || n_bits !== 32) begin
         bad++; $display("FAIL wrap_stream: got %h (%0d bits) want 65432187 (32 bits)", stream[31:0], n_bits);
      end
      total++; if (done_idx !== 35) begin
         bad++; $display("FAIL wrap_no_gap: rd_done at %0d want 35", done_idx);
      end
   endtask

   task automatic test_stall();
      run_readback(16'd3, 1'b0, 1'b1, 1'b0);
      total++; if (stream[11:0] !== 12'h321 || n_bits !== 12) begin
         bad++; $display("FAIL stall_stream: got %h (%0d bits) want 321 (12 bits)", stream[11:0], n_bits);
      end
      total++; if (hold_err !== 0) begin
         bad++; $display("FAIL stall_hold: %0d jtdo changes on idle cycles want 0", hold_err);
      end
      total++; if (n_ce !== 3) begin
         bad++; $display("FAIL stall_rd_ce: got %0d pulses want 3", n_ce);
      end
      total++; if (done_idx !== last_bit_idx + 1 || done_idx !== 26) begin
         bad++; $display("FAIL stall_done_cycle: done=%0d last_bit=%0d want 26/25", done_idx, last_bit_idx);
      end
   endtask

   task automatic test_busy_abuse();
      run_readback(16'd3, 1'b0, 1'b0, 1'b1);
      total++; if (addr_seq[23:0] !== 24'h020100 || n_ce !== 3) begin
         bad++; $display("FAIL abuse_addr: seq=%h n=%0d want 020100 n=3", addr_seq[23:0], n_ce);
      end
      total++; if (stream[11:0] !== 12'h321 || done_idx !== 15) begin
         bad++; $display("FAIL abuse_stream: got %h done=%0d want 321 done=15", stream[11:0], done_idx);
      end
      repeat (3) @(negedge jtck);
      total++; if ({rd_busy, rd_ce} !== 2'b00) begin
         bad++; $display("FAIL abuse_restart: busy/ce=%b want 00", {rd_busy, rd_ce});
      end
   endtask

   task automatic test_reset_abort();
      int seen_done;
      int seen_ce;
      seen_done = 0; seen_ce = 0;
      @(negedge jtck);
      cap_waddr = 16'd3; cap_wrapped = 1'b0; rd_start = 1'b1; jshift = 1'b1;
      @(negedge jtck);
      rd_start = 1'b0;
      // Word 0 shifts during cycles 3..6, word 1 from cycle 7; reset lands in cycle 8.
      repeat (7) @(negedge jtck);
      jrst = 1'b1;
      @(negedge jtck);
      jrst = 1'b0;
      total++; if ({rd_ce, rd_busy, rd_done, jtdo} !== 4'b0000 || rd_addr !== '0) begin
         bad++; $display("FAIL abort_outputs: ce/busy/done/jtdo=%b addr=%0d want 0000 addr=0",
                         {rd_ce, rd_busy, rd_done, jtdo}, rd_addr);
      end
      total++; if (dut.hold_valid !== 1'b0) begin
         bad++; $display("FAIL abort_hold_valid: got %b want 0", dut.hold_valid);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge jtck);
         if (rd_done) seen_done++;
         if (rd_ce) seen_ce++;
      end
      jshift = 1'b0;
      total++; if (seen_done !== 0 || seen_ce !== 0) begin
         bad++; $display("FAIL abort_quiet: rd_done=%0d rd_ce=%0d after reset want 0/0", seen_done, seen_ce);
      end
   endtask

   task automatic test_restart();
      run_readback(16'd3, 1'b0, 1'b0, 1'b0);
      total++; if (stream[11:0] !== 12'h321 || n_ce !== 3 || done_idx !== 15) begin
         bad++; $display("FAIL restart: stream=%h n_ce=%0d done=%0d want 321/3/15", stream[11:0], n_ce, done_idx);
      end
   endtask

   initial begin
      for (int i = 0; i < int'(DEP); i++) mem[i] = DW'(i + 1);
      test_reset();
      test_empty();
      test_linear();
      test_wrapped();
      test_stall();
      test_busy_abuse();
      test_reset_abort();
      test_restart();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
